// File: rtl/data_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_pkg
// Shared encodings for the Data_Memory arbiter:
//   - READ_* / WRITE_* access codes understood by Data_Memory
//   - dump-engine state encoding
// ---------------------------------------------------------------------------
package data_mem_arbiter_pkg;

   localparam logic [1:0] READ_DISABLE   = 2'b00;
   localparam logic [1:0] READ_BYTE      = 2'b01;
   localparam logic [1:0] READ_HALFWORD  = 2'b10;
   localparam logic [1:0] READ_WORD      = 2'b11;

   localparam logic [1:0] WRITE_DISABLE  = 2'b00;
   localparam logic [1:0] WRITE_BYTE     = 2'b01;
   localparam logic [1:0] WRITE_HALFWORD = 2'b10;
   localparam logic [1:0] WRITE_WORD     = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_HOLD    = 3'd3,
      ST_DONE    = 3'd4
   } arb_state_e;

endpackage

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single-port Data_Memory between the MEM stage (CPU port, has
// priority) and the debug memory-dump engine (DBG port). The dump engine reads
// a range of words one at a time and hands each to the debug unit over a
// valid/ready handshake. If DBG has been denied MAX_WAIT consecutive cycles,
// it takes the port anyway and the pipeline is stalled for that one cycle.
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_cpu_*                     MEM-stage access (address, data, enables)
//   o_cpu_data                  Data_Memory read data, passed straight through
//   o_cpu_stall                 MEM stage must re-present its access
//   i_dbg_dump_start/base/count dump request (one-cycle start pulse)
//   o_dbg_data/valid, i_dbg_ready  dumped word handshake
//   o_dbg_busy, o_dbg_done      dump in progress / one-cycle end pulse
//   o_mem_*, i_mem_data         Data_Memory port
// ---------------------------------------------------------------------------
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int NB_DEPTH = 10,
   parameter int NB_DATA  = 32,
   parameter int MAX_WAIT = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [NB_DEPTH-1:0] i_cpu_addr,
   input  logic [NB_DATA-1:0]  i_cpu_data,
   input  logic [1:0]          i_cpu_write_enable,
   input  logic [1:0]          i_cpu_read_enable,
   output logic [NB_DATA-1:0]  o_cpu_data,
   output logic                o_cpu_stall,
   input  logic                i_dbg_dump_start,
   input  logic [NB_DEPTH-1:0] i_dbg_base,
   input  logic [NB_DEPTH:0]   i_dbg_count,
   output logic [NB_DATA-1:0]  o_dbg_data,
   output logic                o_dbg_valid,
   input  logic                i_dbg_ready,
   output logic                o_dbg_busy,
   output logic                o_dbg_done,
   output logic [NB_DEPTH-1:0] o_mem_addr,
   output logic [NB_DATA-1:0]  o_mem_data,
   output logic [1:0]          o_mem_write_enable,
   output logic [1:0]          o_mem_read_enable,
   input  logic [NB_DATA-1:0]  i_mem_data
);

   // Wide enough to hold MAX_WAIT itself (the counter saturates there).
   localparam int NB_WAIT = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [NB_WAIT-1:0]  WAIT_LIMIT = NB_WAIT'(MAX_WAIT);
   localparam logic [NB_WAIT-1:0]  WAIT_ZERO  = {NB_WAIT{1'b0}};
   localparam logic [NB_WAIT-1:0]  WAIT_ONE   = {{(NB_WAIT-1){1'b0}}, 1'b1};
   localparam logic [NB_DEPTH:0]   CNT_ZERO   = {(NB_DEPTH+1){1'b0}};
   localparam logic [NB_DEPTH:0]   CNT_ONE    = {{NB_DEPTH{1'b0}}, 1'b1};
   localparam logic [NB_DEPTH-1:0] ADDR_ZERO  = {NB_DEPTH{1'b0}};
   localparam logic [NB_DEPTH-1:0] ADDR_ONE   = {{(NB_DEPTH-1){1'b0}}, 1'b1};
   localparam logic [NB_DATA-1:0]  DATA_ZERO  = {NB_DATA{1'b0}};

   arb_state_e          state_r;
   arb_state_e          state_nxt_s;
   logic [NB_DEPTH-1:0] addr_r;
   logic [NB_DEPTH:0]   remain_r;
   logic [NB_WAIT-1:0]  wait_r;
   logic [NB_DATA-1:0]  dbg_data_r;
   logic                dbg_valid_r;

   logic                cpu_access_s;
   logic                dbg_grant_s;
   logic                handshake_s;

   assign cpu_access_s = (i_cpu_write_enable != WRITE_DISABLE) ||
                         (i_cpu_read_enable  != READ_DISABLE);

   // DBG wins in ISSUE when the CPU is idle or has been ahead MAX_WAIT times.
   assign dbg_grant_s  = (state_r == ST_ISSUE) &&
                         !(cpu_access_s && (wait_r < WAIT_LIMIT));
   assign handshake_s  = (state_r == ST_HOLD) && dbg_valid_r && i_dbg_ready;

   assign o_cpu_data   = i_mem_data;
   assign o_cpu_stall  = dbg_grant_s && cpu_access_s;
   assign o_dbg_data   = dbg_data_r;
   assign o_dbg_valid  = dbg_valid_r;
   assign o_dbg_busy   = (state_r == ST_ISSUE) || (state_r == ST_CAPTURE) ||
                         (state_r == ST_HOLD);
   assign o_dbg_done   = (state_r == ST_DONE);

   // Data_Memory port mux: CPU by default, dump engine read on a grant.
   always_comb begin
      o_mem_addr         = i_cpu_addr;
      o_mem_data         = i_cpu_data;
      o_mem_write_enable = i_cpu_write_enable;
      o_mem_read_enable  = i_cpu_read_enable;
      if (dbg_grant_s) begin
         o_mem_addr         = addr_r;
         o_mem_data         = DATA_ZERO;
         o_mem_write_enable = WRITE_DISABLE;
         o_mem_read_enable  = READ_WORD;
      end else begin
         o_mem_addr         = i_cpu_addr;
         o_mem_data         = i_cpu_data;
         o_mem_write_enable = i_cpu_write_enable;
         o_mem_read_enable  = i_cpu_read_enable;
      end
   end

   // Next-state logic of the dump engine.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_dbg_dump_start) begin
               state_nxt_s = (i_dbg_count != CNT_ZERO) ? ST_ISSUE : ST_DONE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (dbg_grant_s) begin
               state_nxt_s = ST_CAPTURE;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_CAPTURE: state_nxt_s = ST_HOLD;
         ST_HOLD: begin
            if (handshake_s) begin
               state_nxt_s = (remain_r == CNT_ONE) ? ST_DONE : ST_ISSUE;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Dump datapath: address/remaining counters, starvation counter, word latch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_r      <= ADDR_ZERO;
         remain_r    <= CNT_ZERO;
         wait_r      <= WAIT_ZERO;
         dbg_data_r  <= DATA_ZERO;
         dbg_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               wait_r <= WAIT_ZERO;
               if (i_dbg_dump_start && (i_dbg_count != CNT_ZERO)) begin
                  addr_r   <= i_dbg_base;
                  remain_r <= i_dbg_count;
               end
            end
            ST_ISSUE: begin
               if (dbg_grant_s) begin
                  wait_r <= WAIT_ZERO;
               end else begin
                  wait_r <= wait_r + WAIT_ONE;
               end
            end
            ST_CAPTURE: begin
               // Read data issued in the grant cycle appears now.
               dbg_data_r  <= i_mem_data;
               dbg_valid_r <= 1'b1;
            end
            ST_HOLD: begin
               if (handshake_s) begin
                  dbg_valid_r <= 1'b0;
                  remain_r    <= remain_r - CNT_ONE;
                  // Natural overflow of addr_r gives the modulo-depth wrap.
                  if (remain_r != CNT_ONE) begin
                     addr_r <= addr_r + ADDR_ONE;
                  end
               end
            end
            default: begin
               wait_r <= WAIT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
   import data_mem_arbiter_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [9:0]  i_cpu_addr;
   logic [31:0] i_cpu_data;
   logic [1:0]  i_cpu_write_enable;
   logic [1:0]  i_cpu_read_enable;
   logic [31:0] o_cpu_data;
   logic        o_cpu_stall;
   logic        i_dbg_dump_start;
   logic [9:0]  i_dbg_base;
   logic [10:0] i_dbg_count;
   logic [31:0] o_dbg_data;
   logic        o_dbg_valid;
   logic        i_dbg_ready;
   logic        o_dbg_busy;
   logic        o_dbg_done;
   logic [9:0]  o_mem_addr;
   logic [31:0] o_mem_data;
   logic [1:0]  o_mem_write_enable;
   logic [1:0]  o_mem_read_enable;
   logic [31:0] i_mem_data;

   always #5 i_clk = ~i_clk;

   data_mem_arbiter #(.NB_DEPTH(10), .NB_DATA(32), .MAX_WAIT(8)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_cpu_addr(i_cpu_addr), .i_cpu_data(i_cpu_data),
      .i_cpu_write_enable(i_cpu_write_enable), .i_cpu_read_enable(i_cpu_read_enable),
      .o_cpu_data(o_cpu_data), .o_cpu_stall(o_cpu_stall),
      .i_dbg_dump_start(i_dbg_dump_start), .i_dbg_base(i_dbg_base),
      .i_dbg_count(i_dbg_count), .o_dbg_data(o_dbg_data),
      .o_dbg_valid(o_dbg_valid), .i_dbg_ready(i_dbg_ready),
      .o_dbg_busy(o_dbg_busy), .o_dbg_done(o_dbg_done),
      .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
      .o_mem_write_enable(o_mem_write_enable), .o_mem_read_enable(o_mem_read_enable),
      .i_mem_data(i_mem_data)
   );

   // Data_Memory model: word writes, 1-cycle registered read, zero when disabled.
   logic [31:0] mem [0:1023];
   logic [31:0] mem_q = 32'h0;
   always @(posedge i_clk) begin
      if (o_mem_write_enable == WRITE_WORD) mem[o_mem_addr] <= o_mem_data;
      mem_q <= (o_mem_read_enable != READ_DISABLE) ? mem[o_mem_addr] : 32'h0;
   end
   assign i_mem_data = mem_q;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] sb [$];
   logic [31:0] shadow [0:1023];
   logic [31:0] exp_beat;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic cpu_write(input logic [9:0] a, input logic [31:0] d);
      i_cpu_addr = a; i_cpu_data = d; i_cpu_write_enable = WRITE_WORD;
      tick();
      i_cpu_write_enable = WRITE_DISABLE;
      shadow[a] = d;
   endtask

   task automatic start_dump(input logic [9:0] base, input logic [10:0] cnt);
      for (int i = 0; i < int'(cnt); i++) begin
         logic [9:0] a;
         a = base + 10'(i);
         sb.push_back(shadow[a]);
      end
      i_dbg_base = base; i_dbg_count = cnt; i_dbg_dump_start = 1'b1;
      tick();
      i_dbg_dump_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge i_clk);
         if (o_dbg_done) seen++;
         if ((seen > 0) && !o_dbg_busy && !o_dbg_done) break;
      end
      check({tag, "_done_pulses"}, 64'(seen), 64'd1);
      check({tag, "_busy_dropped"}, 64'(o_dbg_busy), 64'd0);
      check({tag, "_all_beats"}, 64'(sb.size()), 64'd0);
      tick();
   endtask

   // Scoreboard: every accepted beat is compared with the oldest expected word.
   always @(negedge i_clk) begin
      if (i_rst_n && o_dbg_valid && i_dbg_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_beat", 64'(sb.size()), 64'd1);
         end else begin
            exp_beat = sb.pop_front();
            check("dbg_beat", 64'(o_dbg_data), 64'(exp_beat));
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) shadow[i] = 32'h0;
      i_rst_n = 1'b0;
      i_cpu_addr = 10'd0; i_cpu_data = 32'h0;
      i_cpu_write_enable = WRITE_DISABLE; i_cpu_read_enable = READ_DISABLE;
      i_dbg_dump_start = 1'b0; i_dbg_base = 10'd0; i_dbg_count = 11'd0;
      i_dbg_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge i_clk);
      check("rst_busy",  64'(o_dbg_busy),  64'd0);
      check("rst_valid", 64'(o_dbg_valid), 64'd0);
      check("rst_done",  64'(o_dbg_done),  64'd0);
      check("rst_stall", 64'(o_cpu_stall), 64'd0);
      check("rst_data",  64'(o_dbg_data),  64'd0);
      tick();
      i_rst_n = 1'b1;
      tick();

      // CPU write then read, DBG idle
      cpu_write(10'd5, 32'hDEADBEEF);
      i_cpu_addr = 10'd5; i_cpu_read_enable = READ_WORD;
      @(negedge i_clk);
      check("cpu_rd_stall", 64'(o_cpu_stall), 64'd0);
      tick();
      i_cpu_read_enable = READ_DISABLE;
      @(negedge i_clk);
      check("cpu_rd_data", 64'(o_cpu_data), 64'hDEADBEEF);
      check("cpu_rd_stall2", 64'(o_cpu_stall), 64'd0);
      tick();

      // Preload
      cpu_write(10'd0, 32'h10);
      cpu_write(10'd1, 32'h11);
      cpu_write(10'd2, 32'h12);
      cpu_write(10'd3, 32'h13);
      cpu_write(10'd9, 32'h0);
      cpu_write(10'd1023, 32'hAAAA5555);

      // Four-word dump, ready held high
      start_dump(10'd0, 11'd4);
      wait_done(60, "dump4");

      // Address wrap at top of memory
      start_dump(10'd1023, 11'd2);
      wait_done(40, "wrap");

      // Starvation: CPU busy every cycle; grant after 8 denials
      i_cpu_addr = 10'd3; i_cpu_read_enable = READ_WORD;
      start_dump(10'd2, 11'd1);
      for (int i = 0; i <= 8; i++) begin
         if (i == 8) begin
            i_cpu_read_enable = READ_DISABLE;
            i_cpu_addr = 10'd9; i_cpu_data = 32'h99; i_cpu_write_enable = WRITE_WORD;
         end else begin
            i_cpu_addr = 10'd3; i_cpu_read_enable = READ_WORD;
         end
         @(negedge i_clk);
         check($sformatf("starve_stall_%0d", i), 64'(o_cpu_stall), 64'(i == 8));
         if (i == 8) check("starve_cpu_rd", 64'(o_cpu_data), 64'h13);
         tick();
      end
      i_cpu_write_enable = WRITE_DISABLE;
      i_cpu_addr = 10'd9; i_cpu_read_enable = READ_WORD;
      @(negedge i_clk);
      check("capture_stall", 64'(o_cpu_stall), 64'd0);
      tick();
      i_cpu_read_enable = READ_DISABLE;
      i_cpu_data = 32'h99; i_cpu_write_enable = WRITE_WORD;
      @(negedge i_clk);
      check("stalled_write_absent", 64'(o_cpu_data), 64'h0);
      check("starve_valid", 64'(o_dbg_valid), 64'd1);
      tick();
      i_cpu_write_enable = WRITE_DISABLE; i_cpu_read_enable = READ_WORD;
      @(negedge i_clk);
      check("starve_done", 64'(o_dbg_done), 64'd1);
      tick();
      i_cpu_read_enable = READ_DISABLE;
      @(negedge i_clk);
      check("reissued_write", 64'(o_cpu_data), 64'h99);
      check("starve_drained", 64'(sb.size()), 64'd0);
      tick();

      // Back-pressure: ready low in HOLD, CPU proceeds unstalled
      i_dbg_ready = 1'b0;
      start_dump(10'd1, 11'd1);
      for (int k = 0; k < 20; k++) begin
         @(negedge i_clk);
         if (o_dbg_valid) break;
      end
      check("hold_valid_seen", 64'(o_dbg_valid), 64'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         i_cpu_addr = 10'd2; i_cpu_read_enable = READ_WORD;
         @(negedge i_clk);
         check("hold_valid", 64'(o_dbg_valid), 64'd1);
         check("hold_data",  64'(o_dbg_data),  64'h11);
         check("hold_stall", 64'(o_cpu_stall), 64'd0);
         if (k > 0) check("hold_cpu_rd", 64'(o_cpu_data), 64'h12);
      end
      tick();
      i_cpu_read_enable = READ_DISABLE;
      i_dbg_ready = 1'b1;
      wait_done(20, "hold");

      // Reset in HOLD aborts the dump
      i_dbg_ready = 1'b0;
      start_dump(10'd0, 11'd3);
      for (int k = 0; k < 20; k++) begin
         @(negedge i_clk);
         if (o_dbg_valid) break;
      end
      check("abort_valid_seen", 64'(o_dbg_valid), 64'd1);
      #2 i_rst_n = 1'b0;
      #1;
      check("abort_valid", 64'(o_dbg_valid), 64'd0);
      check("abort_data",  64'(o_dbg_data),  64'd0);
      check("abort_busy",  64'(o_dbg_busy),  64'd0);
      check("abort_done",  64'(o_dbg_done),  64'd0);
      check("abort_stall", 64'(o_cpu_stall), 64'd0);
      sb.delete();
      tick();
      i_rst_n = 1'b1;
      i_dbg_ready = 1'b1;
      @(negedge i_clk);
      check("abort_no_done", 64'(o_dbg_done), 64'd0);
      check("abort_idle",    64'(o_dbg_busy), 64'd0);
      tick();

      // Zero-length dump: done next cycle, no memory read
      i_dbg_base = 10'd0; i_dbg_count = 11'd0; i_dbg_dump_start = 1'b1;
      @(negedge i_clk);
      check("zero_no_read0", 64'(o_mem_read_enable), 64'(READ_DISABLE));
      tick();
      i_dbg_dump_start = 1'b0;
      @(negedge i_clk);
      check("zero_done",     64'(o_dbg_done), 64'd1);
      check("zero_busy",     64'(o_dbg_busy), 64'd0);
      check("zero_no_read1", 64'(o_mem_read_enable), 64'(READ_DISABLE));
      tick();
      @(negedge i_clk);
      check("zero_done_once", 64'(o_dbg_done), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
